// File: rtl/gpi_periph.sv
// General-purpose input peripheral: synchronizes and debounces eight pins, latches
// per-pin edge events as sticky W1C flags, drives a maskable irq and a registered read port.
module gpi_periph #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pins,
   input  logic [9:0]  address,
   input  logic [7:0]  data,
   input  logic        write,
   output logic [31:0] data_out,
   output logic        irq
);

   localparam logic [9:0]       ADDR_PIN = 10'h054;
   localparam logic [9:0]       ADDR_EVT = 10'h058;
   localparam logic [9:0]       ADDR_IE  = 10'h05C;
   localparam logic [9:0]       ADDR_POL = 10'h060;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync1_r;
   logic [7:0]       s_r;
   logic [7:0]       q_r;
   logic [7:0]       evt_r;
   logic [7:0]       ie_r;
   logic [7:0]       pol_r;
   logic [31:0]      data_out_r;
   logic [CNT_W-1:0] cnt_r [8];

   logic [7:0]       q_next_s;
   logic [CNT_W-1:0] cnt_next_s [8];
   logic [7:0]       rise_s;
   logic [7:0]       fall_s;
   logic [7:0]       evt_set_s;
   logic [7:0]       w1c_s;
   logic [7:0]       evt_next_s;
   logic [7:0]       rd_sel_s;
   logic             wr_ie_s;
   logic             wr_pol_s;

   // Per-pin debounce: a differing sample must persist DEBOUNCE_CYCLES samples to be accepted
   always_comb begin
      q_next_s = q_r;
      for (int i = 0; i < 8; i++) begin
         cnt_next_s[i] = {CNT_W{1'b0}};
         if (s_r[i] == q_r[i]) begin
            cnt_next_s[i] = {CNT_W{1'b0}};
         end else if (cnt_r[i] == CNT_LAST) begin
            q_next_s[i]   = s_r[i];
            cnt_next_s[i] = {CNT_W{1'b0}};
         end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // Edge detection on the debounced value; a same-edge set beats a W1C clear
   always_comb begin
      rise_s     = ~q_r & q_next_s;
      fall_s     = q_r & ~q_next_s;
      evt_set_s  = (rise_s & ~pol_r) | (fall_s & pol_r);
      evt_next_s = (evt_r & ~w1c_s) | evt_set_s;
   end

   // Write decode for the EVT/IE/POL registers
   always_comb begin
      w1c_s    = 8'h00;
      wr_ie_s  = 1'b0;
      wr_pol_s = 1'b0;
      if (write) begin
         if (address == ADDR_EVT) begin
            w1c_s = data;
         end else begin
            w1c_s = 8'h00;
         end
         wr_ie_s  = (address == ADDR_IE);
         wr_pol_s = (address == ADDR_POL);
      end else begin
         w1c_s    = 8'h00;
         wr_ie_s  = 1'b0;
         wr_pol_s = 1'b0;
      end
   end

   // Read mux; unmapped addresses read as zero
   always_comb begin
      rd_sel_s = 8'h00;
      case (address)
         ADDR_PIN: rd_sel_s = q_r;
         ADDR_EVT: rd_sel_s = evt_r;
         ADDR_IE:  rd_sel_s = ie_r;
         ADDR_POL: rd_sel_s = pol_r;
         default:  rd_sel_s = 8'h00;
      endcase
   end

   // Synchronizer, debounce state and event flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 8'h00;
         s_r     <= 8'h00;
         q_r     <= 8'h00;
         evt_r   <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         sync1_r <= pins;
         s_r     <= sync1_r;
         q_r     <= q_next_s;
         evt_r   <= evt_next_s;
         for (int i = 0; i < 8; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end

   // Software-writable configuration and the registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_r       <= 8'h00;
         pol_r      <= 8'h00;
         data_out_r <= 32'h0000_0000;
      end else begin
         if (wr_ie_s) begin
            ie_r <= data;
         end
         if (wr_pol_s) begin
            pol_r <= data;
         end
         data_out_r <= {24'h00_0000, rd_sel_s};
      end
   end

   assign data_out = data_out_r;
   assign irq      = |(evt_r & ie_r);

endmodule

// File: tb/tb_gpi_periph.sv
// Scoreboard bench for gpi_periph: stimulus queues expected read/irq values, a monitor
// pops and compares them one clock edge after each request.
module tb_gpi_periph;

   localparam int K_NONE = 0;
   localparam int K_DATA = 1;
   localparam int K_IRQ  = 2;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  pins = 8'hFF;
   logic [9:0]  address = 10'h000;
   logic [7:0]  data = 8'h00;
   logic        write = 1'b0;
   logic [31:0] data_out;
   logic        irq;

   logic        chk_req = 1'b0;
   exp_t        sb [$];
   int          vectors = 0;
   int          miscompares = 0;

   gpi_periph #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .pins(pins), .address(address),
      .data(data), .write(write), .data_out(data_out), .irq(irq)
   );

   always #5 clk = ~clk;

   // Monitor: after each posedge that carried a request, compare against the queue head
   always @(posedge clk) begin
      if (chk_req) begin
         exp_t        e;
         logic [31:0] act;
         #1;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_underflow: got request with empty scoreboard");
         end else begin
            e   = sb.pop_front();
            act = (e.kind == K_IRQ) ? {31'h0, irq} : data_out;
            if (act !== e.exp) begin
               miscompares++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   // One bus cycle: drive after negedge, optionally queue an expectation for the next posedge
   task automatic step(input logic [9:0] a, input logic [7:0] d, input logic w,
                       input int kind, input logic [31:0] exp, input string nm);
      exp_t e;
      address = a;
      data    = d;
      write   = w;
      if (kind != K_NONE) begin
         e.kind = kind;
         e.exp  = exp;
         e.name = nm;
         sb.push_back(e);
         chk_req = 1'b1;
      end else begin
         chk_req = 1'b0;
      end
      @(negedge clk);
      write   = 1'b0;
      chk_req = 1'b0;
      address = 10'h000;
      data    = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) step(10'h000, 8'h00, 1'b0, K_NONE, 32'h0, "");
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string nm);
      step(a, 8'h00, 1'b0, K_DATA, exp, nm);
   endtask

   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      step(a, d, 1'b1, K_NONE, 32'h0, "");
   endtask

   task automatic chk_irq(input logic exp, input string nm);
      step(10'h000, 8'h00, 1'b0, K_IRQ, {31'h0, exp}, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      // Reset held with pins high
      rd(10'h054, 32'h0, "rst_pin");
      rd(10'h058, 32'h0, "rst_evt");
      chk_irq(1'b0, "rst_irq");
      rst_n = 1'b1;
      idle(5);
      rd(10'h054, 32'h0000_0000, "pin_edge6_old");
      rd(10'h054, 32'h0000_00FF, "pin_after_rst");
      rd(10'h058, 32'h0000_00FF, "evt_after_rst");
      rd(10'h05C, 32'h0, "ie_rst");
      rd(10'h060, 32'h0, "pol_rst");

      // Pins low again: falling edges with POL=0 add nothing, then clear everything
      pins = 8'h00;
      idle(8);
      rd(10'h058, 32'h0000_00FF, "evt_no_fall");
      wr(10'h058, 8'hFF);
      rd(10'h058, 32'h0, "evt_clr_all");
      rd(10'h054, 32'h0, "pin_low");

      // Three-sample glitch is rejected
      pins = 8'h01;
      idle(3);
      pins = 8'h00;
      idle(8);
      rd(10'h054, 32'h0, "glitch_pin");
      rd(10'h058, 32'h0, "glitch_evt");

      // Four samples are accepted
      pins = 8'h01;
      idle(8);
      rd(10'h054, 32'h0000_0001, "accept_pin");
      rd(10'h058, 32'h0000_0001, "accept_evt");
      wr(10'h058, 8'h01);
      pins = 8'h00;
      idle(8);
      rd(10'h058, 32'h0, "evt_pin0_clr");

      // Interrupt latency: irq rises exactly at capture edge + 5
      wr(10'h05C, 8'h01);
      pins = 8'h01;
      chk_irq(1'b0, "irq_k0");
      chk_irq(1'b0, "irq_k1");
      chk_irq(1'b0, "irq_k2");
      chk_irq(1'b0, "irq_k3");
      chk_irq(1'b0, "irq_k4");
      chk_irq(1'b1, "irq_k5");
      chk_irq(1'b1, "irq_hold");
      step(10'h058, 8'h01, 1'b1, K_IRQ, 32'h0, "irq_w1c");
      rd(10'h058, 32'h0, "evt_after_w1c");

      // Falling-edge select on pin 7
      wr(10'h060, 8'h80);
      pins = 8'h81;
      idle(8);
      rd(10'h058, 32'h0, "pol_no_rise");
      pins = 8'h01;
      idle(8);
      rd(10'h058, 32'h0000_0080, "pol_fall_evt");
      chk_irq(1'b0, "irq_masked");
      wr(10'h05C, 8'h80);
      chk_irq(1'b1, "irq_ie_enable");
      wr(10'h058, 8'h80);
      wr(10'h05C, 8'h00);
      wr(10'h060, 8'h00);

      // W1C of bit 2 on the same edge q[2] rises: set wins, read returns pre-clear value
      pins = 8'h05;
      idle(5);
      step(10'h058, 8'h04, 1'b1, K_DATA, 32'h0, "evt_preclear");
      rd(10'h058, 32'h0000_0004, "collide_set");
      step(10'h058, 8'h00, 1'b1, K_NONE, 32'h0, "");
      rd(10'h058, 32'h0000_0004, "w0_noeffect");

      // Back-to-back reads including an unmapped address
      wr(10'h05C, 8'h5A);
      rd(10'h054, 32'h0000_0005, "rd_pin");
      rd(10'h05C, 32'h0000_005A, "rd_ie");
      rd(10'h3FC, 32'h0000_0000, "rd_unmapped");
      rd(10'h060, 32'h0000_0000, "rd_pol");
      chk_irq(1'b0, "irq_ie_5a");

      idle(2);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gpi_periph.md
# gpi_periph

Memory-mapped general-purpose input peripheral: the read-side counterpart of the GPO output register at 10'h50. It synchronizes and debounces eight external input pins and latches per-pin edge events as sticky flags. It drives a maskable level interrupt and returns pin/event/config state on the data-memory read path, with the same one-cycle registered read latency as data memory.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples that must differ from the stable value before it changes; legal range 1..255.
- CNT_W, 8: width of each per-pin debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously by the system.
- pins  input  8  asynchronous external inputs.
- address  input  10  byte address from the data-memory bus.
- data  input  8  write data, low byte of the store.
- write  input  1  store strobe, sampled on posedge clk.
- data_out  output  32  registered read data, zero-extended.
- irq  output  1  level interrupt, high while any enabled event flag is set.

## Operation
- Register map (10-bit byte address; other addresses ignored on write, read as 0):
  - 10'h54 PIN (RO): debounced stable pin values q[7:0].
  - 10'h58 EVT (R/W1C): sticky edge flags; writing 1 clears that bit, writing 0 has no effect.
  - 10'h5C IE (R/W): interrupt enable mask.
  - 10'h60 POL (R/W): edge select per pin; 0 = rising (q 0->1), 1 = falling (q 1->0).
- Synchronizer: two flops per pin (sync1 <= pins, s <= sync1).
- Debounce, per pin i:
  - If s[i]==q[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: q[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Event set: on the edge where q[i] updates in the POL[i]-selected direction, EVT[i] <= 1.
- Same-edge set and W1C on the same bit: set wins; EVT[i] stays 1.
- Writing POL does not by itself create events; only q transitions do.
- irq = |(EVT & IE), combinational from registers; no glitch source besides register outputs.
- data_out <= {24'b0, selected register} on every posedge, whether or not write is asserted. A read of EVT in the same cycle as its W1C returns the pre-clear value.

## Timing
- Reset values: sync1, s, q = 8'h00; cnt = 0; EVT = 8'h00; IE = 8'h00; POL = 8'h00; data_out = 32'h0; irq = 0.
- A pin that differs from q is captured at posedge k and held until it is accepted:
  - s is valid after edge k+1.
  - q and EVT update at edge k+1+DEBOUNCE_CYCLES.
  - irq rises in the same cycle, if enabled.
- With the default of 4, the pin-to-q latency is 5 edges after capture.
- A pulse shorter than DEBOUNCE_CYCLES synchronized samples resets cnt when s returns to q. q does not change and no event is raised.
- Register writes take effect at the posedge where write is high. IE/POL changes affect irq the next cycle.
- Read latency: address presented before edge n, data_out valid after edge n, matching data memory.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Reset asserted mid-debounce or with pending events clears everything. Pins already high re-debounce after release: q rises after DEBOUNCE_CYCLES+2 edges and raises a rising event if POL=0.

## Test plan
- Reset: hold rst_n=0 with pins=8'hFF. Require data_out=0, irq=0, all registers 0. Release reset: q reads 8'hFF 6 edges later and EVT reads 8'hFF.
- Debounce filter, D=4: after reset, pins[0] pulses high for 3 cycles. Require PIN and EVT to read 0. Then hold pins[0] high for 4 cycles: PIN reads 8'h01 and EVT reads 8'h01.
- Interrupt: write IE=8'h01, then raise pins[0]. Require irq=1 exactly from edge k+5. Write 8'h01 to 10'h58: irq=0 the cycle after the write, EVT reads 0.
- Falling edge: write POL=8'h80, drive pins[7] 1 then 0. Require no event on the rise and EVT=8'h80 after the fall.
- Set/clear collision: time a W1C of EVT bit 2 to coincide with q[2] rising. Require EVT[2]=1 afterwards.
- Read path: read 10'h54, 10'h5C and 10'h3FC back-to-back. Require each data_out one cycle after its address, with 10'h3FC returning 32'h0.
